bids22_round_sequencer: RTL and testbench
=========================================

Name: bids22_round_sequencer

Overview:
Control-side master that drives the bid-master control inputs (C_data, C_op, C_start) and monitors its control outputs (ready, err, roundOver, maxBid). On a single go pulse it replays a full configuration sequence, starts a round, waits for the round to finish and captures the winning bid. It sits between the testbench or host and the bid master, replacing hand-driven opcode streams. Failures are reported with the failing step and error code.

Parameters:
DATAWIDTH, 32, width of C_data, maxBid and configuration words
NUMBIDDERS, 3, bidder count; width of the mask word
TIMEOUT, 1024, maximum cycles to wait for ready or roundOver before failing

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
go  input  1  one-cycle request to run a sequence; ignored while busy
abort  input  1  synchronous abort; returns to IDLE next cycle
cfg_key  input  DATAWIDTH  key used for UNLOCK and LOCK
cfg_x, cfg_y, cfg_z  input  DATAWIDTH  bidder values for LOADX/LOADY/LOADZ
cfg_mask  input  NUMBIDDERS  bidder mask; zero-extended onto C_data
cfg_timer  input  DATAWIDTH  round timer value
cfg_charge  input  DATAWIDTH  bid charge value
C_data  output  DATAWIDTH  operand to bid master
C_op  output  4  opcode: NO_OP=0 UNLOCK=1 LOCK=2 LOADX=3 LOADY=4 LOADZ=5 SETMASK=6 SETTIMER=7 SETBIDCHARGE=8
C_start  output  1  round start strobe
ready  input  1  bid master ready
err  input  3  bid master error: NOERROR=0 BADKEY=1 ALREADYUNLOCKED=2 CSTARTWHENUNLOCKED=3 INVALID_OP=4 DUPLICATEBIDS=5
roundOver  input  1  round complete
maxBid  input  DATAWIDTH  winning bid
busy  output  1  sequence in progress
done  output  1  one-cycle pulse on successful completion
fail  output  1  level; set on failure, cleared by next accepted go
fail_step  output  4  step index at failure (0-7 config ops, 8 start, 9 round wait)
fail_err  output  3  err captured at failure; 0 for a timeout
timed_out  output  1  failure was caused by the TIMEOUT expiring
result  output  DATAWIDTH  maxBid captured at roundOver
rounds_done  output  16  count of successful sequences; wraps at 65535->0

Behaviour:
- Reset: all outputs 0, C_op=NO_OP, state IDLE, step=0, timeout counter=0. Config registers are cleared.
- States: IDLE, ISSUE, CHECK, START, WAITROUND, DONE, FAIL.
- IDLE: when go=1, latch all cfg_* inputs, clear fail, fail_step, fail_err and timed_out, set step=0 and busy=1, then go to ISSUE.
- Step order: 0 UNLOCK(key), 1 LOADX(x), 2 LOADY(y), 3 LOADZ(z), 4 SETMASK(mask), 5 SETTIMER(timer), 6 SETBIDCHARGE(charge), 7 LOCK(key).
- ISSUE: wait for ready=1. In the cycle ready=1, drive C_op and C_data for exactly one cycle, then go to CHECK. At all other times C_op=NO_OP and C_data=0.
- CHECK: sample err one cycle after the issue.
  - err!=0: go to FAIL with fail_step=step and fail_err=err.
  - err=0 and step<7: step+1, return to ISSUE.
  - err=0 and step=7: go to START.
- START: wait for ready=1, then assert C_start=1 for one cycle with C_op=NO_OP, and go to WAITROUND.
- WAITROUND: when roundOver=1, register result<=maxBid, increment rounds_done, and go to DONE.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- FAIL: fail=1, busy=0, return to IDLE the next cycle. fail and the captured fields hold until the next go.
- Timeout: the counter runs in ISSUE, START and WAITROUND and resets on every state change. When it reaches TIMEOUT-1 without the awaited condition, go to FAIL with timed_out=1, fail_err=0 and fail_step set to the current step (8 in START, 9 in WAITROUND).
- abort: highest priority in every non-IDLE state. The next cycle is IDLE with busy=0, C_op=NO_OP and C_start=0; fail and done are not set.
- go while busy is ignored; go and abort together in IDLE: abort wins (no start).
- Asynchronous reset mid-sequence: immediate return to reset values; no partial opcode is held.

Test Plan:
- ready tied 1, err always 0, go with x=10 y=20 z=30 key=0xA5 -> C_op sequence 1,3,4,5,6,7,8,2 on alternating cycles, then C_start pulse; roundOver with maxBid=30 -> result=30, done pulse, rounds_done=1.
- err=BADKEY(1) returned after UNLOCK -> fail=1, fail_step=0, fail_err=1, no further ops issued, busy=0.
- err=DUPLICATEBIDS(5) after LOADZ -> fail_step=3, fail_err=5; a subsequent go clears fail and the rerun completes with done=1.
- ready held 0 with TIMEOUT=16 -> fail after 16 cycles in ISSUE, timed_out=1, fail_step=0, fail_err=0.
- abort asserted in WAITROUND -> IDLE next cycle, busy=0, done=0, fail=0, rounds_done unchanged; go while busy ignored; rounds_done forced to 65535, one more success -> wraps to 0.

Source files
------------

// File: rtl/bids22_round_sequencer.sv
// bids22_round_sequencer
// Control-side master for the bid master. A single go pulse replays the full
// configuration sequence, starts a round and captures the winning bid. It
// reports failures with the failing step and the error code.
module bids22_round_sequencer #(
  parameter int unsigned DATAWIDTH  = 32,
  parameter int unsigned NUMBIDDERS = 3,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  abort,
  input  logic [DATAWIDTH-1:0]  cfg_key,
  input  logic [DATAWIDTH-1:0]  cfg_x,
  input  logic [DATAWIDTH-1:0]  cfg_y,
  input  logic [DATAWIDTH-1:0]  cfg_z,
  input  logic [NUMBIDDERS-1:0] cfg_mask,
  input  logic [DATAWIDTH-1:0]  cfg_timer,
  input  logic [DATAWIDTH-1:0]  cfg_charge,
  output logic [DATAWIDTH-1:0]  C_data,
  output logic [3:0]            C_op,
  output logic                  C_start,
  input  logic                  ready,
  input  logic [2:0]            err,
  input  logic                  roundOver,
  input  logic [DATAWIDTH-1:0]  maxBid,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [3:0]            fail_step,
  output logic [2:0]            fail_err,
  output logic                  timed_out,
  output logic [DATAWIDTH-1:0]  result,
  output logic [15:0]           rounds_done
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  // Bid-master opcodes
  localparam logic [3:0] OpNoOp      = 4'd0;
  localparam logic [3:0] OpUnlock    = 4'd1;
  localparam logic [3:0] OpLock      = 4'd2;
  localparam logic [3:0] OpLoadX     = 4'd3;
  localparam logic [3:0] OpLoadY     = 4'd4;
  localparam logic [3:0] OpLoadZ     = 4'd5;
  localparam logic [3:0] OpSetMask   = 4'd6;
  localparam logic [3:0] OpSetTimer  = 4'd7;
  localparam logic [3:0] OpSetCharge = 4'd8;

  // Step indices reported in fail_step beyond the eight configuration ops
  localparam logic [2:0] StepLast  = 3'd7;
  localparam logic [3:0] StepStart = 4'd8;
  localparam logic [3:0] StepRound = 4'd9;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StCheck,
    StStart,
    StWaitRound,
    StDone,
    StFail
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  counting;
  logic                  timeout_hit;

  logic                  cfg_load;
  logic [DATAWIDTH-1:0]  key_q, x_q, y_q, z_q, timer_q, charge_q;
  logic [NUMBIDDERS-1:0] mask_q;

  logic                  fail_q, fail_d;
  logic [3:0]            fail_step_q, fail_step_d;
  logic [2:0]            fail_err_q, fail_err_d;
  logic                  timed_out_q, timed_out_d;
  logic [DATAWIDTH-1:0]  result_q, result_d;
  logic [15:0]           rounds_done_q, rounds_done_d;

  logic [3:0]            issue_op;
  logic [DATAWIDTH-1:0]  issue_data;

  // State, step and timeout counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      step_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cnt_q   <= cnt_d;
    end
  end

  // Configuration snapshot taken when a sequence is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      z_q      <= '0;
      mask_q   <= '0;
      timer_q  <= '0;
      charge_q <= '0;
    end else if (cfg_load) begin
      key_q    <= cfg_key;
      x_q      <= cfg_x;
      y_q      <= cfg_y;
      z_q      <= cfg_z;
      mask_q   <= cfg_mask;
      timer_q  <= cfg_timer;
      charge_q <= cfg_charge;
    end
  end

  // Status and result registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fail_q        <= 1'b0;
      fail_step_q   <= '0;
      fail_err_q    <= '0;
      timed_out_q   <= 1'b0;
      result_q      <= '0;
      rounds_done_q <= '0;
    end else begin
      fail_q        <= fail_d;
      fail_step_q   <= fail_step_d;
      fail_err_q    <= fail_err_d;
      timed_out_q   <= timed_out_d;
      result_q      <= result_d;
      rounds_done_q <= rounds_done_d;
    end
  end

  // Opcode and operand for the current configuration step
  always_comb begin
    issue_op   = OpNoOp;
    issue_data = '0;
    unique case (step_q)
      3'd0:    begin issue_op = OpUnlock;    issue_data = key_q;                  end
      3'd1:    begin issue_op = OpLoadX;     issue_data = x_q;                    end
      3'd2:    begin issue_op = OpLoadY;     issue_data = y_q;                    end
      3'd3:    begin issue_op = OpLoadZ;     issue_data = z_q;                    end
      3'd4:    begin issue_op = OpSetMask;   issue_data = DATAWIDTH'(mask_q);     end
      3'd5:    begin issue_op = OpSetTimer;  issue_data = timer_q;                end
      3'd6:    begin issue_op = OpSetCharge; issue_data = charge_q;               end
      3'd7:    begin issue_op = OpLock;      issue_data = key_q;                  end
      default: begin issue_op = OpNoOp;      issue_data = '0;                     end
    endcase
  end

  // Next-state, command outputs and failure capture
  always_comb begin
    state_d       = state_q;
    step_d        = step_q;
    fail_d        = fail_q;
    fail_step_d   = fail_step_q;
    fail_err_d    = fail_err_q;
    timed_out_d   = timed_out_q;
    result_d      = result_q;
    rounds_done_d = rounds_done_q;
    cfg_load      = 1'b0;
    C_op          = OpNoOp;
    C_data        = '0;
    C_start       = 1'b0;
    timeout_hit   = (cnt_q == CntLast);

    // abort overrides everything once a sequence is running
    if ((state_q != StIdle) && abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (go && !abort) begin
            cfg_load    = 1'b1;
            fail_d      = 1'b0;
            fail_step_d = '0;
            fail_err_d  = '0;
            timed_out_d = 1'b0;
            step_d      = '0;
            state_d     = StIssue;
          end
        end
        StIssue: begin
          if (ready) begin
            C_op    = issue_op;
            C_data  = issue_data;
            state_d = StCheck;
          end else if (timeout_hit) begin
            fail_d      = 1'b1;
            fail_step_d = {1'b0, step_q};
            fail_err_d  = '0;
            timed_out_d = 1'b1;
            state_d     = StFail;
          end
        end
        StCheck: begin
          // err reflects the op issued in the previous cycle
          if (err != 3'd0) begin
            fail_d      = 1'b1;
            fail_step_d = {1'b0, step_q};
            fail_err_d  = err;
            timed_out_d = 1'b0;
            state_d     = StFail;
          end else if (step_q == StepLast) begin
            state_d = StStart;
          end else begin
            step_d  = step_q + 3'd1;
            state_d = StIssue;
          end
        end
        StStart: begin
          if (ready) begin
            C_start = 1'b1;
            state_d = StWaitRound;
          end else if (timeout_hit) begin
            fail_d      = 1'b1;
            fail_step_d = StepStart;
            fail_err_d  = '0;
            timed_out_d = 1'b1;
            state_d     = StFail;
          end
        end
        StWaitRound: begin
          if (roundOver) begin
            result_d      = maxBid;
            rounds_done_d = rounds_done_q + 16'd1;
            state_d       = StDone;
          end else if (timeout_hit) begin
            fail_d      = 1'b1;
            fail_step_d = StepRound;
            fail_err_d  = '0;
            timed_out_d = 1'b1;
            state_d     = StFail;
          end
        end
        StDone:  state_d = StIdle;
        StFail:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end

    // The wait counter only advances while parked in a waiting state
    counting = (state_q == StIssue) || (state_q == StStart) || (state_q == StWaitRound);
    cnt_d    = (counting && (state_d == state_q)) ? cnt_q + 1'b1 : '0;
  end

  // Status outputs
  always_comb begin
    busy        = (state_q == StIssue) || (state_q == StCheck) ||
                  (state_q == StStart) || (state_q == StWaitRound);
    done        = (state_q == StDone);
    fail        = fail_q;
    fail_step   = fail_step_q;
    fail_err    = fail_err_q;
    timed_out   = timed_out_q;
    result      = result_q;
    rounds_done = rounds_done_q;
  end

  // The start strobe never carries an opcode
  assert property (@(posedge clk) disable iff (!reset_n) C_start |-> (C_op == OpNoOp));

  // Commands are only ever driven while a sequence is in progress
  assert property (@(posedge clk) disable iff (!reset_n)
                   ((C_op != OpNoOp) || C_start) |-> busy);

endmodule

// File: tb/tb_bids22_round_sequencer.sv
// Scoreboard bench for bids22_round_sequencer: stimulus pushes the expected
// command/status events, a negedge monitor pops and compares them.
module tb_bids22_round_sequencer;

  localparam int unsigned DW = 32;
  localparam int unsigned NB = 3;
  localparam int unsigned TO = 16;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           go = 1'b0;
  logic           abort = 1'b0;
  logic [DW-1:0]  cfg_key = '0, cfg_x = '0, cfg_y = '0, cfg_z = '0;
  logic [NB-1:0]  cfg_mask = '0;
  logic [DW-1:0]  cfg_timer = '0, cfg_charge = '0;
  logic           ready = 1'b1;
  logic [2:0]     err = 3'd0;
  logic           roundOver = 1'b0;
  logic [DW-1:0]  maxBid = '0;
  logic [DW-1:0]  C_data;
  logic [3:0]     C_op;
  logic           C_start, busy, done, fail, timed_out;
  logic [3:0]     fail_step;
  logic [2:0]     fail_err;
  logic [DW-1:0]  result;
  logic [15:0]    rounds_done;

  bids22_round_sequencer #(
    .DATAWIDTH (DW),
    .NUMBIDDERS(NB),
    .TIMEOUT   (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .go         (go),
    .abort      (abort),
    .cfg_key    (cfg_key),
    .cfg_x      (cfg_x),
    .cfg_y      (cfg_y),
    .cfg_z      (cfg_z),
    .cfg_mask   (cfg_mask),
    .cfg_timer  (cfg_timer),
    .cfg_charge (cfg_charge),
    .C_data     (C_data),
    .C_op       (C_op),
    .C_start    (C_start),
    .ready      (ready),
    .err        (err),
    .roundOver  (roundOver),
    .maxBid     (maxBid),
    .busy       (busy),
    .done       (done),
    .fail       (fail),
    .fail_step  (fail_step),
    .fail_err   (fail_err),
    .timed_out  (timed_out),
    .result     (result),
    .rounds_done(rounds_done)
  );

  always #5 clk = ~clk;

  // kind: 0 fail, 1 op, 2 start, 3 done
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  a;
    logic [2:0]  b;
    logic        c;
    logic        bsy;
    logic [31:0] d;
    logic [15:0] e;
  } ev_t;

  ev_t         exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          g = 0;
  int          start_cnt = 0, end_cnt = 0, start_cyc = 0, fail_cyc = 0;
  logic [3:0]  trig_op = 4'd0;
  logic [2:0]  trig_code = 3'd0;
  logic [3:0]  resp_op = 4'd0;
  logic        fail_prev = 1'b0;
  logic [15:0] rounds_model = 16'd0;

  function automatic ev_t mk(logic [1:0] k, logic [3:0] a, logic [2:0] b, logic c,
                             logic bsy, logic [31:0] d, logic [15:0] e);
    ev_t v;
    v.kind = k; v.a = a; v.b = b; v.c = c; v.bsy = bsy; v.d = d; v.e = e;
    return v;
  endfunction

  task automatic compare_ev(input ev_t got, input string name);
    ev_t want;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: got event %h, none expected", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        miscompares++;
        $display("FAIL %s: got %h want %h", name, got, want);
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Opcode table in sequence order: 1,3,4,5,6,7,8,2
  function automatic logic [3:0] op_of(int i);
    case (i)
      0: return 4'd1;
      1: return 4'd3;
      2: return 4'd4;
      3: return 4'd5;
      4: return 4'd6;
      5: return 4'd7;
      6: return 4'd8;
      default: return 4'd2;
    endcase
  endfunction

  function automatic logic [31:0] data_of(int i);
    case (i)
      1: return cfg_x;
      2: return cfg_y;
      3: return cfg_z;
      4: return {29'd0, cfg_mask};
      5: return cfg_timer;
      6: return cfg_charge;
      default: return cfg_key;
    endcase
  endfunction

  task automatic push_ops(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(mk(2'd1, op_of(i), 3'd0, 1'b0, 1'b1, data_of(i), 16'd0));
  endtask

  task automatic push_start();
    exp_q.push_back(mk(2'd2, 4'd0, 3'd0, 1'b0, 1'b1, 32'd0, 16'd0));
  endtask

  task automatic push_done(input logic [31:0] res, input logic [15:0] rnd);
    exp_q.push_back(mk(2'd3, 4'd0, 3'd0, 1'b0, 1'b0, res, rnd));
  endtask

  task automatic push_fail(input logic [3:0] step, input logic [2:0] e, input logic to);
    exp_q.push_back(mk(2'd0, step, e, to, 1'b0, 32'd0, 16'd0));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [31:0] k, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] z, input logic [2:0] m, input logic [31:0] t,
                         input logic [31:0] c);
    cfg_key = k; cfg_x = x; cfg_y = y; cfg_z = z; cfg_mask = m; cfg_timer = t; cfg_charge = c;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    g  = cyc;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_start(input int s0, input int budget);
    for (int i = 0; i < budget && start_cnt == s0; i++) tick();
    check("start_seen", 64'(start_cnt != s0), 64'd1);
  endtask

  task automatic wait_end(input int e0, input int budget);
    for (int i = 0; i < budget && end_cnt == e0; i++) tick();
    check("end_seen", 64'(end_cnt != e0), 64'd1);
  endtask

  task automatic round_over(input logic [31:0] v);
    tick();
    tick();
    maxBid    = v;
    roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
  endtask

  task automatic q_empty(input string name);
    check(name, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor plus bid-master err responder
  initial forever begin
    @(negedge clk);
    err     = (resp_op != 4'd0 && resp_op == trig_op) ? trig_code : 3'd0;
    resp_op = C_op;
    if (reset_n) begin
      if (C_op != 4'd0) compare_ev(mk(2'd1, C_op, 3'd0, 1'b0, busy, C_data, 16'd0), "op");
      if (C_start) begin
        compare_ev(mk(2'd2, C_op, 3'd0, 1'b0, busy, C_data, 16'd0), "start");
        start_cnt++;
        start_cyc = cyc;
      end
      if (done) begin
        compare_ev(mk(2'd3, 4'd0, 3'd0, 1'b0, busy, result, rounds_done), "done");
        end_cnt++;
      end
      if (fail && !fail_prev) begin
        compare_ev(mk(2'd0, fail_step, fail_err, timed_out, busy, 32'd0, 16'd0), "fail");
        end_cnt++;
        fail_cyc = cyc;
      end
    end
    fail_prev = fail;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({C_op, C_data, C_start, busy, done, fail, fail_step, fail_err,
                                timed_out, rounds_done}), 64'd0);
    check("reset_result", 64'(result), 64'd0);
    reset_n = 1'b1;
    tick();
    check("idle_outputs", 64'({C_op, C_start, busy, done, fail}), 64'd0);

    // T1: full successful sequence
    set_cfg(32'hA5, 32'd10, 32'd20, 32'd30, 3'b101, 32'd100, 32'd2);
    push_ops(8);
    push_start();
    rounds_model = rounds_model + 16'd1;
    push_done(32'd30, rounds_model);
    s0 = start_cnt; e0 = end_cnt;
    pulse_go();
    wait_start(s0, 40);
    check("start_cadence", 64'(start_cyc - g), 64'd17);
    round_over(32'd30);
    wait_end(e0, 20);
    check("t1_result", 64'(result), 64'd30);
    check("t1_rounds", 64'(rounds_done), 64'd1);
    repeat (2) tick();
    q_empty("t1_queue");

    // T2: BADKEY after UNLOCK
    trig_op = 4'd1; trig_code = 3'd1;
    push_ops(1);
    push_fail(4'd0, 3'd1, 1'b0);
    e0 = end_cnt;
    pulse_go();
    wait_end(e0, 20);
    repeat (4) tick();
    check("t2_fail_level", 64'({fail, busy}), 64'b10);
    q_empty("t2_queue");

    // T3: DUPLICATEBIDS after LOADZ, then a clean rerun
    trig_op = 4'd5; trig_code = 3'd5;
    set_cfg(32'h1234, 32'd7, 32'd8, 32'd9, 3'b011, 32'd50, 32'd1);
    push_ops(4);
    push_fail(4'd3, 3'd5, 1'b0);
    e0 = end_cnt;
    pulse_go();
    wait_end(e0, 30);
    repeat (3) tick();
    q_empty("t3_queue");
    trig_op = 4'd0; trig_code = 3'd0;
    push_ops(8);
    push_start();
    rounds_model = rounds_model + 16'd1;
    push_done(32'd77, rounds_model);
    s0 = start_cnt; e0 = end_cnt;
    pulse_go();
    check("t3_go_clears", 64'({fail, fail_step, fail_err, timed_out, busy}), 64'd1);
    wait_start(s0, 40);
    round_over(32'd77);
    wait_end(e0, 20);
    q_empty("t3_rerun_queue");

    // T4: ready stuck low -> ISSUE timeout
    ready = 1'b0;
    push_fail(4'd0, 3'd0, 1'b1);
    e0 = end_cnt;
    pulse_go();
    wait_end(e0, 40);
    check("t4_timeout_cycles", 64'(fail_cyc - g), 64'd17);
    ready = 1'b1;
    repeat (2) tick();
    q_empty("t4_queue");

    // T4b: no roundOver -> WAITROUND timeout
    push_ops(8);
    push_start();
    push_fail(4'd9, 3'd0, 1'b1);
    e0 = end_cnt;
    pulse_go();
    wait_end(e0, 60);
    repeat (2) tick();
    q_empty("t4b_queue");

    // T5: go while busy ignored, abort in WAITROUND
    set_cfg(32'hBEEF, 32'd1, 32'd2, 32'd3, 3'b111, 32'd9, 32'd4);
    push_ops(8);
    push_start();
    s0 = start_cnt;
    pulse_go();
    repeat (4) tick();
    cfg_key = 32'hDEAD;
    go = 1'b1;
    tick();
    go = 1'b0;
    wait_start(s0, 40);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_after_abort", 64'({busy, done, fail, C_op, C_start}), 64'd0);
    maxBid = 32'd99; roundOver = 1'b1;
    tick();
    roundOver = 1'b0;
    repeat (3) tick();
    check("t5_rounds_kept", 64'(rounds_done), 64'(rounds_model));
    q_empty("t5_queue");

    // go and abort together in IDLE: no start
    go = 1'b1; abort = 1'b1;
    tick();
    go = 1'b0; abort = 1'b0;
    check("go_abort_idle", 64'(busy), 64'd0);
    repeat (3) tick();
    q_empty("go_abort_queue");

    // T6: rounds_done wraps 65535 -> 0
    force dut.rounds_done_q = 16'hFFFF;
    tick();
    release dut.rounds_done_q;
    tick();
    check("t6_preset", 64'(rounds_done), 64'hFFFF);
    rounds_model = 16'hFFFF;
    set_cfg(32'h55, 32'd4, 32'd5, 32'd6, 3'b001, 32'd3, 32'd2);
    push_ops(8);
    push_start();
    rounds_model = rounds_model + 16'd1;
    push_done(32'd55, rounds_model);
    s0 = start_cnt; e0 = end_cnt;
    pulse_go();
    wait_start(s0, 40);
    round_over(32'd55);
    wait_end(e0, 20);
    check("t6_wrapped", 64'(rounds_done), 64'd0);
    repeat (2) tick();
    q_empty("t6_queue");

    // T7: asynchronous reset mid-sequence
    push_ops(8);
    pulse_go();
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("t7_async_reset", 64'({C_op, C_data, C_start, busy, done, fail}), 64'd0);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("t7_after_reset", 64'({busy, rounds_done}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
